core_pipe_stage: RTL and testbench

//  Generic inter-stage pipeline buffer with valid/ready handshake, flush and stall.

---
 rtl/core_pipe_stage_pkg.sv | 32 +++
 rtl/core_pipe_stage_if.sv | 17 +
 rtl/core_pipe_stage.sv | 101 ++++++++++
 tb/tb_core_pipe_stage.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pipe_stage_pkg.sv
// core_pipe_stage_pkg
//   Shared types and helpers for pipeline stage buffers.
//   Stage bundles are packed structs; they are cast onto the WIDTH-bit payload
//   of core_pipe_stage at the instantiation site.
//   Ports: none (package).
package core_pipe_stage_pkg;

    // Decode -> execute payload (32 bits).
    typedef struct packed {
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [19:0] imm;
    } x_bundle_t;

    // Execute -> writeback payload (38 bits).
    typedef struct packed {
        logic        wb_en;
        logic [4:0]  rd;
        logic [31:0] result;
    } w_bundle_t;

    // Pointer width for a DEPTH-entry queue; at least one bit even when DEPTH is 1.
    function automatic int unsigned pipe_ptr_w(int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Occupancy counter width: must represent 0..depth inclusive.
    function automatic int unsigned pipe_cnt_w(int unsigned depth);
        return (depth > 0) ? $clog2(depth + 1) : 1;
    endfunction

endpackage

// File: rtl/core_pipe_stage_if.sv
// core_pipe_stage_if
//   Valid/ready handshake bundle carrying a WIDTH-bit payload.
//   Signals:
//     valid  producer has a payload
//     ready  consumer accepts the payload this cycle
//     data   payload
//   Modports: master drives valid/data, slave drives ready.
interface core_pipe_stage_if #(
    parameter int unsigned WIDTH = 32
);
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/core_pipe_stage.sv
// core_pipe_stage
//   Inter-stage pipeline buffer: DEPTH-entry elastic queue with valid/ready
//   handshake, flush and stall. DEPTH=1, READY_PASS=1 behaves as a single
//   register stage boundary.
//   Ports:
//     i_clk      clock, all state on posedge
//     i_rst_n    synchronous reset, active low
//     i_flush    drop all held entries and the current input
//     i_stall    block push only; the pop side keeps draining
//     in_if      upstream handshake (slave): valid/data in, ready out
//     out_if     downstream handshake (master): valid/data out, ready in
//     o_count    current occupancy
module core_pipe_stage
    import core_pipe_stage_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned DEPTH      = 2,
    parameter bit          READY_PASS = 1'b0
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_flush,
    input  logic                          i_stall,
    core_pipe_stage_if.slave              in_if,
    core_pipe_stage_if.master             out_if,
    output logic [pipe_cnt_w(DEPTH)-1:0]  o_count
);

    localparam int unsigned PtrW = pipe_ptr_w(DEPTH);
    localparam int unsigned CntW = pipe_cnt_w(DEPTH);
    localparam logic [CntW-1:0] CntMax  = CntW'(DEPTH);
    localparam logic [PtrW-1:0] PtrLast = PtrW'(DEPTH - 1);

    if (DEPTH < 1) begin : g_bad_depth
        $error("core_pipe_stage: DEPTH must be >= 1");
    end

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PtrW-1:0]  r_rd_ptr;
    logic [PtrW-1:0]  r_wr_ptr;
    logic [CntW-1:0]  r_count;

    logic w_full;
    logic w_push;
    logic w_pop;

    function automatic logic [PtrW-1:0] ptr_inc(logic [PtrW-1:0] p);
        return (p == PtrLast) ? '0 : p + 1'b1;
    endfunction

    assign w_full = (r_count == CntMax);

    // Flush forces ready so the upstream sees its payload consumed (and dropped).
    assign in_if.ready = i_flush | (~i_stall & (~w_full | (READY_PASS & out_if.ready)));

    assign w_push = in_if.valid & in_if.ready & ~i_flush;
    assign w_pop  = out_if.valid & out_if.ready & ~i_flush;

    // No bypass: a push into an empty queue shows up on out_if one cycle later.
    assign out_if.valid = (r_count != '0);
    assign out_if.data  = r_mem[r_rd_ptr];
    assign o_count      = r_count;

    // Storage is intentionally not reset.
    always_ff @(posedge i_clk) begin
        if (i_rst_n && w_push) begin
            r_mem[r_wr_ptr] <= in_if.data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            // Simultaneous push and pop leaves occupancy unchanged.
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    a_count_bound : assert property (@(posedge i_clk) disable iff (!i_rst_n)
        r_count <= CntMax);

    a_no_overflow : assert property (@(posedge i_clk) disable iff (!i_rst_n)
        (w_push && w_full) |-> w_pop);

    a_data_stable : assert property (@(posedge i_clk) disable iff (!i_rst_n)
        (out_if.valid && !out_if.ready && !i_flush) |=> $stable(out_if.data));

endmodule

// File: tb/tb_core_pipe_stage.sv
module tb_core_pipe_stage;

    logic clk = 1'b0;
    logic rst_n;
    logic flush;
    logic stall;

    logic [1:0] cnt0;
    logic [0:0] cnt1;
    logic [1:0] cnt2;

    int checks = 0;
    int errors = 0;

    logic [31:0] sb0[$];
    logic [31:0] sb1[$];
    logic [31:0] sb2[$];

    always #5 clk = ~clk;

    core_pipe_stage_if #(.WIDTH(32)) if_in0 ();
    core_pipe_stage_if #(.WIDTH(32)) if_out0 ();
    core_pipe_stage_if #(.WIDTH(32)) if_in1 ();
    core_pipe_stage_if #(.WIDTH(32)) if_out1 ();
    core_pipe_stage_if #(.WIDTH(32)) if_in2 ();
    core_pipe_stage_if #(.WIDTH(32)) if_out2 ();

    // u0: registered-ready, two entries
    core_pipe_stage #(.WIDTH(32), .DEPTH(2), .READY_PASS(1'b0)) u0 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_flush (flush),
        .i_stall (stall),
        .in_if   (if_in0),
        .out_if  (if_out0),
        .o_count (cnt0)
    );

    // u1: legacy single-register stage
    core_pipe_stage #(.WIDTH(32), .DEPTH(1), .READY_PASS(1'b1)) u1 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_flush (flush),
        .i_stall (stall),
        .in_if   (if_in1),
        .out_if  (if_out1),
        .o_count (cnt1)
    );

    // u2: non-power-of-two depth
    core_pipe_stage #(.WIDTH(32), .DEPTH(3), .READY_PASS(1'b0)) u2 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_flush (flush),
        .i_stall (stall),
        .in_if   (if_in2),
        .out_if  (if_out2),
        .o_count (cnt2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Sample handshakes mid-cycle, update scoreboards, advance to just after the edge.
    task automatic step();
        logic [31:0] exp;
        @(negedge clk);
        if (!rst_n || flush) begin
            sb0.delete();
            sb1.delete();
            sb2.delete();
        end else begin
            if (if_out0.valid && if_out0.ready) begin
                exp = (sb0.size() != 0) ? sb0.pop_front() : 32'hDEAD_BEEF;
                chk("sb0_out", if_out0.data, exp);
            end
            if (if_in0.valid && if_in0.ready) sb0.push_back(if_in0.data);
            if (if_out1.valid && if_out1.ready) begin
                exp = (sb1.size() != 0) ? sb1.pop_front() : 32'hDEAD_BEEF;
                chk("sb1_out", if_out1.data, exp);
            end
            if (if_in1.valid && if_in1.ready) sb1.push_back(if_in1.data);
            if (if_out2.valid && if_out2.ready) begin
                exp = (sb2.size() != 0) ? sb2.pop_front() : 32'hDEAD_BEEF;
                chk("sb2_out", if_out2.data, exp);
            end
            if (if_in2.valid && if_in2.ready) sb2.push_back(if_in2.data);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        stall = 1'b0;
        if_in0.valid = 1'b0; if_in0.data = '0; if_out0.ready = 1'b0;
        if_in1.valid = 1'b0; if_in1.data = '0; if_out1.ready = 1'b0;
        if_in2.valid = 1'b0; if_in2.data = '0; if_out2.ready = 1'b0;
        step();
        step();

        // Reset state
        chk("rst_count0", 32'(cnt0), 32'd0);
        chk("rst_valid0", 32'(if_out0.valid), 32'd0);
        chk("rst_ready0", 32'(if_in0.ready), 32'd1);
        chk("rst_count1", 32'(cnt1), 32'd0);
        chk("rst_count2", 32'(cnt2), 32'd0);
        rst_n = 1'b1;

        // T1: fill two entries, registered-ready blocks even with out_ready
        if_in0.valid = 1'b1; if_in0.data = 32'hA1;
        step();
        chk("t1_count1", 32'(cnt0), 32'd1);
        if_in0.data = 32'hB2;
        step();
        chk("t1_count2", 32'(cnt0), 32'd2);
        chk("t1_full_rdy", 32'(if_in0.ready), 32'd0);
        if_out0.ready = 1'b1;
        #1;
        chk("t1_full_rdy_or", 32'(if_in0.ready), 32'd0);
        chk("t1_head_a", if_out0.data, 32'hA1);
        if_in0.valid = 1'b0;
        step();
        chk("t1_head_b", if_out0.data, 32'hB2);
        chk("t1_count_after", 32'(cnt0), 32'd1);
        step();
        chk("t1_empty_valid", 32'(if_out0.valid), 32'd0);
        step();
        chk("t1_empty_hold", 32'(cnt0), 32'd0);
        if_out0.ready = 1'b0;

        // T2: single register, pass-through ready when full
        if_in1.valid = 1'b1; if_in1.data = 32'hA0;
        step();
        if_in1.data = 32'hC0;
        #1;
        chk("t2_full_rdy0", 32'(if_in1.ready), 32'd0);
        if_out1.ready = 1'b1;
        #1;
        chk("t2_full_rdy1", 32'(if_in1.ready), 32'd1);
        step();
        chk("t2_count", 32'(cnt1), 32'd1);
        chk("t2_head_c", if_out1.data, 32'hC0);
        chk("t2_rdy", 32'(if_in1.ready), 32'd1);
        if_in1.valid = 1'b0;
        step();
        chk("t2_drained", 32'(cnt1), 32'd0);
        if_out1.ready = 1'b0;

        // T3: DEPTH=3 pointer wrap
        if_in2.valid = 1'b1; if_in2.data = 32'h11;
        step();
        if_in2.data = 32'h22;
        step();
        if_in2.data = 32'h33;
        step();
        chk("t3_count3", 32'(cnt2), 32'd3);
        chk("t3_full_rdy", 32'(if_in2.ready), 32'd0);
        if_in2.valid = 1'b0; if_out2.ready = 1'b1;
        step();
        if_out2.ready = 1'b0; if_in2.valid = 1'b1; if_in2.data = 32'h44;
        step();
        chk("t3_wr_wrap", 32'(u2.r_wr_ptr), 32'd1);
        chk("t3_head", if_out2.data, 32'h22);
        if_in2.valid = 1'b0; if_out2.ready = 1'b1;
        step();
        step();
        step();
        chk("t3_empty", 32'(if_out2.valid), 32'd0);
        if_out2.ready = 1'b0;

        // T4: flush drops entries and the current input
        if_in0.valid = 1'b1; if_in0.data = 32'h01;
        step();
        if_in0.data = 32'h02;
        step();
        chk("t4_count2", 32'(cnt0), 32'd2);
        flush = 1'b1; if_in0.data = 32'h03; if_out0.ready = 1'b1;
        #1;
        chk("t4_flush_rdy", 32'(if_in0.ready), 32'd1);
        step();
        flush = 1'b0; if_in0.valid = 1'b0;
        chk("t4_count0", 32'(cnt0), 32'd0);
        chk("t4_valid0", 32'(if_out0.valid), 32'd0);
        if_in0.valid = 1'b1; if_in0.data = 32'h05;
        step();
        if_in0.valid = 1'b0;
        chk("t4_next_head", if_out0.data, 32'h05);
        step();
        if_out0.ready = 1'b0;

        // T5: stall blocks push, pops keep draining
        if_in0.valid = 1'b1; if_in0.data = 32'h51;
        step();
        if_in0.data = 32'h52;
        step();
        stall = 1'b1; if_in0.data = 32'h53; if_out0.ready = 1'b1;
        #1;
        chk("t5_stall_rdy", 32'(if_in0.ready), 32'd0);
        step();
        chk("t5_count1", 32'(cnt0), 32'd1);
        step();
        chk("t5_bubble", 32'(if_out0.valid), 32'd0);
        chk("t5_stall_rdy_e", 32'(if_in0.ready), 32'd0);
        if_in0.valid = 1'b0;
        stall = 1'b0;
        #1;
        chk("t5_unstall_rdy", 32'(if_in0.ready), 32'd1);
        if_out0.ready = 1'b0;

        // T6: reset mid-stream
        if_in0.valid = 1'b1; if_in0.data = 32'h61;
        step();
        if_in0.data = 32'h62;
        step();
        chk("t6_count2", 32'(cnt0), 32'd2);
        if_in0.valid = 1'b0; rst_n = 1'b0;
        step();
        chk("t6_rst_count", 32'(cnt0), 32'd0);
        chk("t6_rst_valid", 32'(if_out0.valid), 32'd0);
        rst_n = 1'b1; if_in0.valid = 1'b1; if_in0.data = 32'h63; if_out0.ready = 1'b1;
        #1;
        chk("t6_pre_valid", 32'(if_out0.valid), 32'd0);
        step();
        if_in0.valid = 1'b0;
        chk("t6_first_valid", 32'(if_out0.valid), 32'd1);
        chk("t6_first_data", if_out0.data, 32'h63);
        step();
        if_out0.ready = 1'b0;

        chk("sb0_left", 32'(sb0.size()), 32'd0);
        chk("sb1_left", 32'(sb1.size()), 32'd0);
        chk("sb2_left", 32'(sb2.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
